// File: rtl/cipher_fifo_param.sv
// Synchronous FIFO that stores each word XORed with a rotating key stream.
// It can decrypt on read and keeps count, almost-full and sticky over/underflow status.
module cipher_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Cen,
  input  logic              Wr_En,
  input  logic [DATA_W-1:0] Data_IN,
  input  logic              Rd_En,
  input  logic              Key_Load,
  input  logic [DATA_W-1:0] Cipher_Key,
  input  logic              Decrypt_En,
  output logic [DATA_W-1:0] QUE_Data_Out,
  output logic              QUE_Valid,
  output logic              QUE_Empty,
  output logic              QUE_Full,
  output logic              QUE_Last,
  output logic              QUE_Almost_Full,
  output logic [ADDR_W:0]   QUE_Count,
  output logic              QUE_Overflow,
  output logic              QUE_Underflow
);

  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_AF  = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1]};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [DATA_W-1:0] ks_wr, ks_rd, kw, kr, c;
  logic [ADDR_W:0]   count_nxt;
  logic              key_ld, wr_ok, rd_ok;

  // A key load only takes effect on an empty queue, so both streams restart in step.
  assign key_ld = Cen & Key_Load & QUE_Empty;
  assign kw     = key_ld ? Cipher_Key : ks_wr;
  assign kr     = key_ld ? Cipher_Key : ks_rd;
  assign rd_ok  = Cen & Rd_En & ~QUE_Empty;
  assign wr_ok  = Cen & Wr_En & (~QUE_Full | rd_ok);
  assign c      = mem[rp];

  always_comb begin
    count_nxt = QUE_Count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = QUE_Count + CNT_ONE;
      2'b01:   count_nxt = QUE_Count - CNT_ONE;
      default: count_nxt = QUE_Count;
    endcase
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wp] <= Data_IN ^ kw;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wp              <= '0;
      rp              <= '0;
      ks_wr           <= '0;
      ks_rd           <= '0;
      QUE_Count       <= '0;
      QUE_Data_Out    <= '0;
      QUE_Valid       <= 1'b0;
      QUE_Empty       <= 1'b1;
      QUE_Full        <= 1'b0;
      QUE_Last        <= 1'b0;
      QUE_Almost_Full <= 1'b0;
      QUE_Overflow    <= 1'b0;
      QUE_Underflow   <= 1'b0;
    end else begin
      ks_wr     <= wr_ok ? rotl1(kw) : kw;
      ks_rd     <= rd_ok ? rotl1(kr) : kr;
      QUE_Valid <= rd_ok;
      if (wr_ok) wp <= wp + PTR_ONE;
      if (rd_ok) begin
        rp           <= rp + PTR_ONE;
        QUE_Data_Out <= Decrypt_En ? (c ^ kr) : c;
      end
      QUE_Count       <= count_nxt;
      QUE_Empty       <= (count_nxt == '0);
      QUE_Full        <= (count_nxt == CNT_MAX);
      QUE_Last        <= (count_nxt == CNT_ONE);
      QUE_Almost_Full <= (count_nxt >= CNT_AF);
      if (Cen & Wr_En & ~wr_ok)    QUE_Overflow  <= 1'b1;
      if (Cen & Rd_En & QUE_Empty) QUE_Underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cipher_fifo_param.sv
// Directed bench for cipher_fifo_param (DATA_W=32, DEPTH=16, AFULL_LVL=12).
module tb_cipher_fifo_param;

  logic        Clk = 1'b0;
  logic        reset, Cen, Wr_En, Rd_En, Key_Load, Decrypt_En;
  logic [31:0] Data_IN, Cipher_Key, QUE_Data_Out;
  logic        QUE_Valid, QUE_Empty, QUE_Full, QUE_Last, QUE_Almost_Full;
  logic        QUE_Overflow, QUE_Underflow;
  logic [4:0]  QUE_Count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  cipher_fifo_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .Clk(Clk), .reset(reset), .Cen(Cen), .Wr_En(Wr_En), .Data_IN(Data_IN),
    .Rd_En(Rd_En), .Key_Load(Key_Load), .Cipher_Key(Cipher_Key),
    .Decrypt_En(Decrypt_En), .QUE_Data_Out(QUE_Data_Out), .QUE_Valid(QUE_Valid),
    .QUE_Empty(QUE_Empty), .QUE_Full(QUE_Full), .QUE_Last(QUE_Last),
    .QUE_Almost_Full(QUE_Almost_Full), .QUE_Count(QUE_Count),
    .QUE_Overflow(QUE_Overflow), .QUE_Underflow(QUE_Underflow)
  );

  typedef struct {
    logic        cen, wr, rd, kl, dec;
    logic [31:0] din, key;
    logic [31:0] e_dout;
    logic        e_valid;
    logic [4:0]  e_count;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic step(input logic cen, input logic wr, input logic [31:0] din, input logic rd,
                      input logic kl, input logic [31:0] key, input logic dec);
    Cen = cen; Wr_En = wr; Data_IN = din; Rd_En = rd;
    Key_Load = kl; Cipher_Key = key; Decrypt_En = dec;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic ovf, input logic udf);
    chk({tag, ".count"}, 32'(QUE_Count), 32'(cnt));
    chk({tag, ".empty"}, 32'(QUE_Empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(QUE_Full),  32'(cnt == 16));
    chk({tag, ".last"},  32'(QUE_Last),  32'(cnt == 1));
    chk({tag, ".afull"}, 32'(QUE_Almost_Full), 32'(cnt >= 12));
    chk({tag, ".ovf"},   32'(QUE_Overflow),  32'(ovf));
    chk({tag, ".udf"},   32'(QUE_Underflow), 32'(udf));
  endtask

  initial begin
    // Key-stream vectors, starting from an empty queue whose last output was 16.
    tv[0]  = '{1,1,0,1,0, 32'h0,        32'hA5A50001, 32'h10,       0, 1};
    tv[1]  = '{1,1,0,0,0, 32'h0,        32'h0,        32'h10,       0, 2};
    tv[2]  = '{1,0,1,0,0, 32'h0,        32'h0,        32'hA5A50001, 1, 1};
    tv[3]  = '{1,0,1,0,0, 32'h0,        32'h0,        32'h4B4A0003, 1, 0};
    tv[4]  = '{1,0,0,0,0, 32'h0,        32'h0,        32'h4B4A0003, 0, 0};
    tv[5]  = '{1,1,0,1,0, 32'h0,        32'hA5A50001, 32'h4B4A0003, 0, 1};
    tv[6]  = '{1,1,0,0,0, 32'h0,        32'h0,        32'h4B4A0003, 0, 2};
    tv[7]  = '{1,0,1,0,1, 32'h0,        32'h0,        32'h0,        1, 1};
    tv[8]  = '{1,0,1,0,1, 32'h0,        32'h0,        32'h0,        1, 0};
    // Load key 0, then a load attempted on a non-empty queue must be ignored.
    tv[9]  = '{1,1,0,1,0, 32'h000000FF, 32'h0,        32'h0,        0, 1};
    tv[10] = '{1,1,0,1,0, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 2};
    tv[11] = '{1,0,1,0,0, 32'h0,        32'h0,        32'h000000FF, 1, 1};
    tv[12] = '{1,0,1,0,0, 32'h0,        32'h0,        32'h0,        1, 0};

    Cen = 0; Wr_En = 0; Rd_En = 0; Key_Load = 0; Decrypt_En = 0;
    Data_IN = 0; Cipher_Key = 0; reset = 1'b1;
    @(posedge Clk); #1;
    do_reset();

    // Reset state, then fill with key 0.
    chk_flags("rst", 0, 0, 0);
    chk("rst.dout",  QUE_Data_Out, 32'h0);
    chk("rst.valid", 32'(QUE_Valid), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 32'(i), 0, 0, 0, 0);
      chk_flags($sformatf("fill%0d", i), i, 0, 0);
    end
    step(1, 1, 32'd17, 0, 0, 0, 0);
    chk_flags("wr17", 16, 1, 0);

    // Drain with decrypt on.
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 1, 0, 0, 1);
      chk($sformatf("drain%0d.dout", i), QUE_Data_Out, 32'(i));
      chk($sformatf("drain%0d.valid", i), 32'(QUE_Valid), 32'h1);
      chk_flags($sformatf("drain%0d", i), 16 - i, 1, 0);
    end
    step(1, 0, 0, 1, 0, 0, 1);
    chk_flags("rd_empty", 0, 1, 1);
    chk("rd_empty.dout",  QUE_Data_Out, 32'd16);
    chk("rd_empty.valid", 32'(QUE_Valid), 32'h0);

    // Key-stream table.
    for (int v = 0; v < 13; v++) begin
      step(tv[v].cen, tv[v].wr, tv[v].din, tv[v].rd, tv[v].kl, tv[v].key, tv[v].dec);
      chk($sformatf("tv%0d.dout", v),  QUE_Data_Out, tv[v].e_dout);
      chk($sformatf("tv%0d.valid", v), 32'(QUE_Valid), 32'(tv[v].e_valid));
      chk($sformatf("tv%0d.count", v), 32'(QUE_Count), 32'(tv[v].e_count));
    end

    // Full with simultaneous read and write.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, 32'h100 + 32'(i), 0, 0, 0, 1);
    chk_flags("full", 16, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 32'h200 + 32'(k), 1, 0, 0, 1);
      chk($sformatf("rw%0d.dout", k), QUE_Data_Out, 32'h100 + 32'(k));
      chk_flags($sformatf("rw%0d", k), 16, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 0, 0, 1);
      chk($sformatf("order%0d", i), QUE_Data_Out,
          (i < 12) ? 32'h104 + 32'(i) : 32'h200 + 32'(i - 12));
    end
    step(1, 1, 32'h300, 1, 0, 0, 1);
    chk_flags("rw_empty", 1, 0, 1);
    chk("rw_empty.valid", 32'(QUE_Valid), 32'h0);
    chk("rw_empty.dout",  QUE_Data_Out, 32'h203);
    step(1, 0, 0, 1, 0, 0, 1);
    chk("rw_empty.rd", QUE_Data_Out, 32'h300);

    // Reset mid-operation.
    for (int i = 0; i < 5; i++) step(1, 1, 32'h40 + 32'(i), 0, 0, 0, 1);
    chk("pre_rst.count", 32'(QUE_Count), 32'd5);
    do_reset();
    chk_flags("mid_rst", 0, 0, 0);
    chk("mid_rst.dout", QUE_Data_Out, 32'h0);
    step(1, 0, 0, 1, 0, 0, 1);
    chk_flags("mid_rst.rd", 0, 0, 1);
    chk("mid_rst.valid", 32'(QUE_Valid), 32'h0);

    // Chip enable low: nothing moves, key load is blocked too.
    step(1, 1, 32'h77, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("cen.pre", QUE_Data_Out, 32'h77);
    for (int k = 0; k < 10; k++) begin
      step(0, k[0], 32'hAAAA0000 + 32'(k), ~k[0], k[1], 32'hDEADBEEF, k[0]);
      chk_flags($sformatf("cen%0d", k), 0, 0, 1);
      chk($sformatf("cen%0d.dout", k), QUE_Data_Out, 32'h77);
      chk($sformatf("cen%0d.valid", k), 32'(QUE_Valid), 32'h0);
    end
    step(1, 1, 32'h55, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("cen.key_blocked", QUE_Data_Out, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
